// File: rtl/vga_timing_gen.sv
// vga_timing_gen: divided-clock VGA raster counters with registered sync, blanking and pixel/frame strobes
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] H_Count_Value,
  output logic [9:0] V_Count_Value,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_en,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);

  logic [DW-1:0] r_div;
  logic [9:0]    r_h, r_v;
  logic          r_hs, r_vs, r_vo, r_pe, r_fs;
  logic          w_step, w_h_wrap;
  logic [9:0]    w_h_nxt, w_v_nxt;

  assign w_step   = r_div == D_LAST;
  assign w_h_wrap = r_h == H_LAST;
  assign w_h_nxt  = w_h_wrap ? 10'd0 : r_h + 10'd1;
  assign w_v_nxt  = !w_h_wrap ? r_v : (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;

  // pixel-rate divider; wrapping marks the pixel step
  always_ff @(posedge clk or posedge rst)
    if (rst) r_div <= '0;
    else     r_div <= w_step ? '0 : r_div + 1'b1;

  // raster position and decoded outputs, all derived from the next position so they move together
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_h  <= H_LAST;
      r_v  <= V_LAST;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_vo <= 1'b0;
      r_pe <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_pe <= w_step;
      r_fs <= w_step && w_h_nxt == 10'd0 && w_v_nxt == 10'd0;
      if (w_step) begin
        r_h  <= w_h_nxt;
        r_v  <= w_v_nxt;
        r_hs <= !(w_h_nxt >= HS_BEG && w_h_nxt <= HS_END);
        r_vs <= !(w_v_nxt >= VS_BEG && w_v_nxt <= VS_END);
        r_vo <= w_h_nxt < H_VIS && w_v_nxt < V_VIS;
      end
    end

  assign H_Count_Value = r_h;
  assign V_Count_Value = r_v;
  assign hsync         = r_hs;
  assign vsync         = r_vs;
  assign video_on      = r_vo;
  assign pix_en        = r_pe;
  assign frame_start   = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized reset/run sequences checked against an arithmetic raster model
module tb_vga_timing_gen;
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 5;
  localparam int SVA = 10, SVF = 2, SVS = 3, SVB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n = 0;
  int   tests = 0;
  int   fails = 0;

  logic [9:0] d_h, d_v, a_h, a_v, b_h, b_v;
  logic d_hs, d_vs, d_vo, d_pe, d_fs;
  logic a_hs, a_vs, a_vo, a_pe, a_fs;
  logic b_hs, b_vs, b_vo, b_pe, b_fs;

  always #5 clk = ~clk;

  // count of rising edges since reset release; the model is a pure function of it
  always @(posedge clk or posedge rst)
    if (rst) n <= 0;
    else     n <= n + 1;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .H_Count_Value(d_h), .V_Count_Value(d_v),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vo), .pix_en(d_pe), .frame_start(d_fs));

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .CLK_DIV(3)) u_s3 (
    .clk(clk), .rst(rst), .H_Count_Value(a_h), .V_Count_Value(a_v),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .pix_en(a_pe), .frame_start(a_fs));

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .CLK_DIV(1)) u_s1 (
    .clk(clk), .rst(rst), .H_Count_Value(b_h), .V_Count_Value(b_v),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .pix_en(b_pe), .frame_start(b_fs));

  function automatic logic [24:0] model(int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb, int cd, int k);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int p  = k / cd;
    int h, v, idx;
    logic pe, fs, hso, vso, vo;
    if (p == 0) begin
      h = ht - 1; v = vt - 1; pe = 1'b0; fs = 1'b0;
    end else begin
      idx = (p - 1) % (ht * vt);
      h = idx % ht;
      v = idx / ht;
      pe = (k % cd) == 0;
      fs = pe && idx == 0;
    end
    hso = !(h >= ha + hf && h < ha + hf + hs);
    vso = !(v >= va + vf && v < va + vf + vs);
    vo  = h < ha && v < va;
    return {10'(h), 10'(v), hso, vso, vo, pe, fs};
  endfunction

  task automatic chk(string tag, logic [24:0] got, logic [24:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s n=%0d got h=%0d v=%0d hs/vs/vo/pe/fs=%b required h=%0d v=%0d hs/vs/vo/pe/fs=%b",
             tag, n, got[24:15], got[14:5], got[4:0], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  task automatic chk_all();
    chk("def", {d_h, d_v, d_hs, d_vs, d_vo, d_pe, d_fs}, model(640, 16, 96, 48, 480, 10, 2, 33, 2, n));
    chk("s3",  {a_h, a_v, a_hs, a_vs, a_vo, a_pe, a_fs}, model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 3, n));
    chk("s1",  {b_h, b_v, b_hs, b_vs, b_vo, b_pe, b_fs}, model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1, n));
  endtask

  task automatic chk_cnt(string tag, int got, int exp);
    tests++;
    assert (got == exp) else begin
      fails++;
      $error("FAIL %s count got=%0d required=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int hs_low, fs_d, fs_a, fs_b, run, hold;
    int sf = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);
    hs_low = 0; fs_d = 0; fs_a = 0; fs_b = 0;
    // reset held from time zero: reset values must already be present
    repeat (2) @(negedge clk);
    chk_all();
    rst = 1'b0;
    // first long run: every cycle against the model, plus pulse/width counts
    for (int i = 1; i <= 4000; i++) begin
      @(negedge clk);
      chk_all();
      if (i <= 1600 && !d_hs) hs_low++;
      fs_d += int'(d_fs);
      fs_a += int'(a_fs);
      fs_b += int'(b_fs);
    end
    chk_cnt("hsync_low_clks", hs_low, 96 * 2);
    chk_cnt("fs_def", fs_d, (4000 / 2 + 420000 - 1) / 420000);
    chk_cnt("fs_s3", fs_a, (4000 / 3 + sf - 1) / sf);
    chk_cnt("fs_s1", fs_b, (4000 + sf - 1) / sf);
    // random asynchronous reset pulses mid-cycle followed by random-length runs
    for (int s = 0; s < 10; s++) begin
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      chk_all();
      hold = $urandom_range(1, 3);
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        chk_all();
      end
      rst = 1'b0;
      run = $urandom_range(20, 2500);
      for (int j = 0; j < run; j++) begin
        @(negedge clk);
        chk_all();
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: horizontal sync width, pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch, lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vertical sync width, lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch, lines.
REQ-009 SHALL have parameter CLK_DIV, default 2: clk cycles per pixel, legal range 1..16.
REQ-010 SHALL have port clk  input  1  system clock (50 MHz); single clock domain.
REQ-011 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-012 SHALL have port H_Count_Value  output  10  current pixel column, 0..H_TOTAL-1.
REQ-013 SHALL have port V_Count_Value  output  10  current line, 0..V_TOTAL-1.
REQ-014 SHALL have port hsync  output  1  horizontal sync, active-low.
REQ-015 SHALL have port vsync  output  1  vertical sync, active-low.
REQ-016 SHALL have port video_on  output  1  high while the current position is visible.
REQ-017 SHALL have port pix_en  output  1  one-clk pulse marking the first cycle of each new pixel.
REQ-018 SHALL have port frame_start  output  1  one-clk pulse when position (0,0) is first presented.

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-020 SHALL use a divider counter 0..CLK_DIV-1 that increments every clk and wraps to 0; a pixel step occurs on the edge where the divider wraps.
REQ-021 SHALL advance H_Count_Value by 1 on each pixel step; H_TOTAL-1 wraps to 0.
REQ-022 SHALL advance V_Count_Value by 1 only on a pixel step where H wraps; V_TOTAL-1 wraps to 0, so H and V wrap on the same edge.
REQ-023 SHALL hold all counters between pixel steps.
REQ-024 SHALL register all outputs; hsync, vsync and video_on SHALL change on the same edge as the counters and always correspond to the presented H/V values.
REQ-025 SHALL drive hsync low iff H is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 by default).
REQ-026 SHALL drive vsync low iff V is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 by default).
REQ-027 SHALL drive video_on high iff H < H_ACTIVE and V < V_ACTIVE.
REQ-028 SHALL drive pix_en high for exactly the one clk cycle following each pixel step; with CLK_DIV=1, pix_en SHALL be constantly high after the first step.
REQ-029 SHALL drive frame_start high for exactly one clk cycle: the cycle after the step that produces (0,0), coincident with pix_en.
REQ-030 SHALL have a pixel period of CLK_DIV clk, a line period of H_TOTAL*CLK_DIV clk, and a frame period of H_TOTAL*V_TOTAL*CLK_DIV clk.

Reset
REQ-031 SHALL, while rst is high and without any clk edge, force divider=0, H=H_TOTAL-1, V=V_TOTAL-1, hsync=1, vsync=1, video_on=0, pix_en=0, frame_start=0.
REQ-032 SHALL, after rst deasserts, make the first pixel step at the CLK_DIV-th rising edge, wrapping to (0,0) and asserting frame_start.
REQ-033 SHALL, on rst asserted mid-frame, abandon the frame immediately and restart per REQ-032 on release.

Verification
REQ-034 SHALL cover reset release with CLK_DIV=2 -> 2nd rising edge gives H=0, V=0, video_on=1, pix_en=1, frame_start=1; next cycle pix_en=0, frame_start=0.
REQ-035 SHALL cover a line with defaults -> hsync low for exactly 96 pixel steps (192 clk) starting at H=656; H 799->0 every 1600 clk.
REQ-036 SHALL cover a full frame -> vsync low only at V=490,491; frame_start exactly once per 840000 clk.
REQ-037 SHALL cover the visible boundary -> (639,479) video_on=1; (640,479) video_on=0; (0,480) video_on=0; (799,524) then (0,0) video_on=1.
REQ-038 SHALL cover async rst pulse at H=300, V=200 -> outputs reach REQ-031 values before the next clk edge; restart at (0,0) with frame_start.
REQ-039 SHALL cover CLK_DIV=1 -> pix_en high every cycle, line period 800 clk, frame_start once per 420000 clk.
